// File: rtl/lcd_defs.sv
// ---------------------------------------------------------------------------
// lcd_defs
// Shared definitions for the HD44780 string driver:
//   - LCD command byte constants used by the init and refresh sequences
//   - top-level sequencer state encoding (lcd_state_t)
//   - nibble writer phase encoding (nib_phase_t)
//   - helpers returning the init-sequence bytes by index
// ---------------------------------------------------------------------------
package lcd_defs;

   localparam logic [7:0] LCD_FUNC_4BIT = 8'h28;
   localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
   localparam logic [7:0] LCD_ENTRY     = 8'h06;
   localparam logic [7:0] LCD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_LINE1     = 8'h80;
   localparam logic [7:0] LCD_LINE2     = 8'hC0;

   // Byte slots of one refresh: 0 = line-1 address, 1..16 = line 1 chars,
   // 17 = line-2 address, 18..33 = line 2 chars.
   localparam logic [5:0] REFRESH_LINE2_IDX = 6'd17;
   localparam logic [5:0] REFRESH_LAST_IDX  = 6'd33;

   typedef enum logic [2:0] {
      S_PWRUP,
      S_INIT_NIB,
      S_INIT_CMD,
      S_IDLE,
      S_REFRESH,
      S_WAIT
   } lcd_state_t;

   typedef enum logic [2:0] {
      W_IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      W_WAIT
   } nib_phase_t;

   // The wake-up nibbles travel in the high half of a byte so the writer
   // can treat them like any other byte with only the high nibble sent.
   function automatic logic [7:0] init_nib_byte(input logic [1:0] idx);
      return (idx == 2'd3) ? 8'h20 : 8'h30;
   endfunction

   function automatic logic [7:0] init_cmd_byte(input logic [1:0] idx);
      logic [7:0] b;
      unique case (idx)
         2'd0:    b = LCD_FUNC_4BIT;
         2'd1:    b = LCD_DISP_ON;
         2'd2:    b = LCD_ENTRY;
         default: b = LCD_CLEAR;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// ---------------------------------------------------------------------------
// lcd_nibble_writer
// Sends one byte (or a single high nibble) to a 4-bit HD44780 bus and then
// waits out the controller's execution time.
//   CCLK          in   system clock
//   rst           in   asynchronous reset, active-low
//   start         in   accept {rs, data_byte, single_nibble, long_wait}
//                      (honoured when idle or in the cycle done is high)
//   rs            in   register select for this byte
//   data_byte     in   byte to send (high nibble first)
//   single_nibble in   send only data_byte[7:4], then INIT_WAIT_CYC
//   long_wait     in   use CLEAR_WAIT_CYC instead of CMD_WAIT_CYC
//   done          out  high in the last wait cycle of the current byte
//   lcd_e         out  enable strobe
//   lcd_rs        out  register select pin
//   lcd_d         out  data nibble D7..D4
// Each nibble is 1 setup cycle, E_PULSE_CYC cycles of E high, 1 hold cycle.
// ---------------------------------------------------------------------------
module lcd_nibble_writer
   import lcd_defs::*;
#(
   parameter int unsigned E_PULSE_CYC    = 12,
   parameter int unsigned INIT_WAIT_CYC  = 205000,
   parameter int unsigned CMD_WAIT_CYC   = 2000,
   parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
   input  logic       CCLK,
   input  logic       rst,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data_byte,
   input  logic       single_nibble,
   input  logic       long_wait,
   output logic       done,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [3:0] lcd_d
);

   nib_phase_t  phase_q, phase_n;
   logic [31:0] cnt_q, cnt_n;
   logic        e_q, e_n;
   logic        rs_q, rs_n;
   logic [3:0]  d_q, d_n;
   logic [3:0]  low_nib_q, low_nib_n;
   logic        low_pending_q, low_pending_n;
   logic        single_q, single_n;
   logic        long_q, long_n;
   logic [31:0] wait_len;
   logic        accept;

   // Post-byte wait length follows the kind of byte that was sent.
   assign wait_len = single_q ? 32'(INIT_WAIT_CYC) :
                     (long_q ? 32'(CLEAR_WAIT_CYC) : 32'(CMD_WAIT_CYC));

   // done is combinational so the sequencer can hand over the next byte in
   // the same cycle, which keeps consecutive bytes gapless.
   assign done   = (phase_q == W_WAIT) && (cnt_q == wait_len - 32'd1);
   assign accept = start && ((phase_q == W_IDLE) || done);

   // Next-state logic for the nibble phases; a newly accepted byte overrides
   // whatever the phase logic decided, loading the high nibble for setup.
   always_comb begin
      phase_n       = phase_q;
      cnt_n         = cnt_q;
      e_n           = e_q;
      rs_n          = rs_q;
      d_n           = d_q;
      low_nib_n     = low_nib_q;
      low_pending_n = low_pending_q;
      single_n      = single_q;
      long_n        = long_q;

      unique case (phase_q)
         W_IDLE: begin
            phase_n = W_IDLE;
         end
         W_SETUP: begin
            e_n     = 1'b1;
            cnt_n   = 32'd0;
            phase_n = W_PULSE;
         end
         W_PULSE: begin
            if (cnt_q == 32'(E_PULSE_CYC) - 32'd1) begin
               e_n     = 1'b0;
               phase_n = W_HOLD;
            end else begin
               cnt_n = cnt_q + 32'd1;
            end
         end
         W_HOLD: begin
            if (low_pending_q) begin
               d_n           = low_nib_q;
               low_pending_n = 1'b0;
               phase_n       = W_SETUP;
            end else begin
               cnt_n   = 32'd0;
               phase_n = W_WAIT;
            end
         end
         W_WAIT: begin
            if (done) begin
               phase_n = W_IDLE;
            end else begin
               cnt_n = cnt_q + 32'd1;
            end
         end
         default: begin
            phase_n = W_IDLE;
         end
      endcase

      if (accept) begin
         phase_n       = W_SETUP;
         cnt_n         = 32'd0;
         e_n           = 1'b0;
         rs_n          = rs;
         d_n           = data_byte[7:4];
         low_nib_n     = data_byte[3:0];
         low_pending_n = !single_nibble;
         single_n      = single_nibble;
         long_n        = long_wait;
      end
   end

   // All pin drivers are flops; the async reset drops E immediately.
   always_ff @(posedge CCLK or negedge rst) begin
      if (!rst) begin
         phase_q       <= W_IDLE;
         cnt_q         <= 32'd0;
         e_q           <= 1'b0;
         rs_q          <= 1'b0;
         d_q           <= 4'h0;
         low_nib_q     <= 4'h0;
         low_pending_q <= 1'b0;
         single_q      <= 1'b0;
         long_q        <= 1'b0;
      end else begin
         phase_q       <= phase_n;
         cnt_q         <= cnt_n;
         e_q           <= e_n;
         rs_q          <= rs_n;
         d_q           <= d_n;
         low_nib_q     <= low_nib_n;
         low_pending_q <= low_pending_n;
         single_q      <= single_n;
         long_q        <= long_n;
      end
   end

   assign lcd_e  = e_q;
   assign lcd_rs = rs_q;
   assign lcd_d  = d_q;

endmodule

// File: rtl/lcd_string_driver.sv
// ---------------------------------------------------------------------------
// lcd_string_driver
// Consumer of the 32-character display string: initialises a 16x2 HD44780
// LCD in 4-bit mode, then rewrites both lines on every refresh request.
//   CCLK     in   system clock
//   rst      in   asynchronous reset, active-low
//   cls      in   refresh request, sampled every cycle
//   strdata  in   32 ASCII chars, char0 = bits[255:248]
//   busy     out  high during init and while a refresh is in progress
//   lcd_rs   out  0 = command, 1 = data
//   lcd_rw   out  always 0 (write only)
//   lcd_e    out  enable strobe
//   lcd_d    out  data nibble D7..D4
// ---------------------------------------------------------------------------
module lcd_string_driver
   import lcd_defs::*;
#(
   parameter int unsigned POWERUP_CYC    = 750000,
   parameter int unsigned INIT_WAIT_CYC  = 205000,
   parameter int unsigned E_PULSE_CYC    = 12,
   parameter int unsigned CMD_WAIT_CYC   = 2000,
   parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
   input  logic         CCLK,
   input  logic         rst,
   input  logic         cls,
   input  logic [255:0] strdata,
   output logic         busy,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic         lcd_e,
   output logic [3:0]   lcd_d
);

   lcd_state_t   state_q, state_n;
   logic [5:0]   idx_q, idx_n;
   logic [31:0]  pwr_cnt_q, pwr_cnt_n;
   logic         pending_q, pending_n;
   logic         busy_q;
   logic [255:0] snap_q;
   logic         snap_load;

   logic         wr_start;
   logic         wr_rs;
   logic [7:0]   wr_byte;
   logic         wr_single;
   logic         wr_long;
   logic         wr_done;

   // Byte for refresh slot i, taken from the frozen frame.
   function automatic logic [7:0] refresh_byte(input logic [5:0] i,
                                               input logic [255:0] s);
      logic [255:0] sh;
      int           ch;
      if (i == 6'd0) return LCD_LINE1;
      if (i == REFRESH_LINE2_IDX) return LCD_LINE2;
      ch = (i < REFRESH_LINE2_IDX) ? int'(i) - 1 : int'(i) - 2;
      sh = s << (8 * ch);
      return sh[255:248];
   endfunction

   // Byte sequencer. A byte is always issued in the same cycle as the
   // transition that calls for it (end of power-up, writer done, or cls in
   // idle), so the writer's setup cycle immediately follows. Requests seen
   // while busy collapse into the pending flag and are served when the
   // last byte of the current sequence finishes.
   always_comb begin
      state_n   = state_q;
      idx_n     = idx_q;
      pwr_cnt_n = pwr_cnt_q;
      pending_n = pending_q || (cls && (state_q != S_IDLE));
      snap_load = 1'b0;
      wr_start  = 1'b0;
      wr_rs     = 1'b0;
      wr_byte   = 8'h00;
      wr_single = 1'b0;
      wr_long   = 1'b0;

      unique case (state_q)
         S_PWRUP: begin
            if (pwr_cnt_q == 32'(POWERUP_CYC) - 32'd1) begin
               state_n   = S_INIT_NIB;
               idx_n     = 6'd0;
               wr_start  = 1'b1;
               wr_byte   = init_nib_byte(2'd0);
               wr_single = 1'b1;
            end else begin
               pwr_cnt_n = pwr_cnt_q + 32'd1;
            end
         end
         S_INIT_NIB: begin
            if (wr_done) begin
               wr_start = 1'b1;
               if (idx_q == 6'd3) begin
                  state_n = S_INIT_CMD;
                  idx_n   = 6'd0;
                  wr_byte = init_cmd_byte(2'd0);
               end else begin
                  idx_n     = idx_q + 6'd1;
                  wr_byte   = init_nib_byte(idx_n[1:0]);
                  wr_single = 1'b1;
               end
            end
         end
         S_INIT_CMD: begin
            if (wr_done) begin
               idx_n    = idx_q + 6'd1;
               wr_start = 1'b1;
               wr_byte  = init_cmd_byte(idx_n[1:0]);
               wr_long  = (wr_byte == LCD_CLEAR);
               if (idx_q == 6'd2) begin
                  state_n = S_WAIT;
               end
            end
         end
         S_IDLE: begin
            if (cls) begin
               state_n   = S_REFRESH;
               idx_n     = 6'd0;
               snap_load = 1'b1;
               wr_start  = 1'b1;
               wr_byte   = LCD_LINE1;
            end
         end
         S_REFRESH: begin
            if (wr_done) begin
               idx_n    = idx_q + 6'd1;
               wr_start = 1'b1;
               wr_byte  = refresh_byte(idx_n, snap_q);
               wr_rs    = (idx_n != REFRESH_LINE2_IDX);
               if (idx_n == REFRESH_LAST_IDX) begin
                  state_n = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (wr_done) begin
               if (pending_n) begin
                  pending_n = 1'b0;
                  state_n   = S_REFRESH;
                  idx_n     = 6'd0;
                  snap_load = 1'b1;
                  wr_start  = 1'b1;
                  wr_byte   = LCD_LINE1;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         default: begin
            state_n = S_PWRUP;
         end
      endcase
   end

   // Sequencer registers; busy is registered from the next state so it
   // rises the cycle after cls and falls the cycle after the final wait.
   always_ff @(posedge CCLK or negedge rst) begin
      if (!rst) begin
         state_q   <= S_PWRUP;
         idx_q     <= 6'd0;
         pwr_cnt_q <= 32'd0;
         pending_q <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_n;
         idx_q     <= idx_n;
         pwr_cnt_q <= pwr_cnt_n;
         pending_q <= pending_n;
         busy_q    <= (state_n != S_IDLE);
      end
   end

   // Frame snapshot, so the string may change while a refresh is running.
   always_ff @(posedge CCLK) begin
      if (snap_load) begin
         snap_q <= strdata;
      end
   end

   lcd_nibble_writer #(
      .E_PULSE_CYC    (E_PULSE_CYC),
      .INIT_WAIT_CYC  (INIT_WAIT_CYC),
      .CMD_WAIT_CYC   (CMD_WAIT_CYC),
      .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
   ) u_writer (
      .CCLK          (CCLK),
      .rst           (rst),
      .start         (wr_start),
      .rs            (wr_rs),
      .data_byte     (wr_byte),
      .single_nibble (wr_single),
      .long_wait     (wr_long),
      .done          (wr_done),
      .lcd_e         (lcd_e),
      .lcd_rs        (lcd_rs),
      .lcd_d         (lcd_d)
   );

   assign busy   = busy_q;
   assign lcd_rw = 1'b0;

endmodule

// File: doc/lcd_string_driver.md
Name: lcd_string_driver

Overview:
- Reader/consumer end of the 256-bit display-string interface: takes the 32-character string (`strdata`) and the refresh strobe (`cls`) that the top level produces.
- Drives an HD44780-compatible character LCD (16x2, 4-bit bus, write-only).
- Runs the power-on init sequence, then on every refresh writes line 1 from `strdata[255:128]` and line 2 from `strdata[127:0]`.
- Sits between the top-level string builder and the LCD pins.

Parameters:
POWERUP_CYC, 750000, idle cycles after reset before the first init nibble (15 ms @ 50 MHz)
INIT_WAIT_CYC, 205000, wait after each init-only nibble (4.1 ms)
E_PULSE_CYC, 12, cycles `lcd_e` is held high per nibble (>=230 ns)
CMD_WAIT_CYC, 2000, wait after every byte except clear (40 us)
CLEAR_WAIT_CYC, 82000, wait after the 0x01 clear command (1.64 ms)

Ports:
CCLK  in  1  system clock
rst  in  1  asynchronous reset, active-low
cls  in  1  refresh request, sampled every cycle
strdata  in  256  32 ASCII chars; char0 = bits[255:248] (line 1 col 0), char31 = bits[7:0]
busy  out  1  high while init or a refresh is in progress
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  constant 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_d  out  4  LCD data nibble (D7..D4)

Behaviour:
- Reset (`rst`=0, async, also mid-operation):
  - Outputs: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_d`=0, `busy`=1.
  - Clears the pending flag and all counters; state goes to S_PWRUP.
  - An in-flight nibble is abandoned immediately (E drops the same instant).
- Nibble cycle:
  - 1 setup cycle: E=0, RS/D valid.
  - E_PULSE_CYC cycles: E=1.
  - 1 hold cycle: E=0, RS/D unchanged.
- Byte:
  - High nibble then low nibble, back to back.
  - Then CMD_WAIT_CYC idle cycles, or CLEAR_WAIT_CYC if the byte is a command with value 0x01.
  - Byte time = 2*(E_PULSE_CYC+2) + wait.
- FSM states: S_PWRUP, S_INIT_NIB, S_INIT_CMD, S_IDLE, S_REFRESH, S_WAIT.
- S_PWRUP: counts POWERUP_CYC cycles.
- S_INIT_NIB: single command nibbles 0x3, 0x3, 0x3, 0x2, each followed by INIT_WAIT_CYC.
- S_INIT_CMD: command bytes 0x28, 0x0C, 0x06, 0x01.
- After the last init byte's wait, go to S_IDLE with `busy`=0.
- Refresh sequence:
  - Command 0x80.
  - 16 data bytes (RS=1), char0..char15.
  - Command 0xC0.
  - 16 data bytes, char16..char31.
  - Total 34 bytes, 68 E pulses.
- Refresh start:
  - In S_IDLE, `cls`=1 starts a refresh the next cycle.
  - `strdata` is snapshotted into an internal 256-bit register on that same edge, so later changes do not tear the frame.
  - `busy` rises the cycle after `cls` is sampled.
- Pending refresh:
  - `cls`=1 while `busy`=1 (including during init) sets a pending flag; multiple requests collapse into one.
  - On completion with pending set: clear the flag, re-snapshot, start a new refresh; `busy` stays 1 with no idle cycle.
- `cls` held high continuously gives back-to-back refreshes; this is legal.
- `busy` falls to 0 on the cycle after the final wait of a refresh expires, if nothing is pending.
- Character bytes are sent verbatim; there is no ASCII translation.
- `lcd_rw` is tied to 0 at all times.

Decomposition:
- Shared package lcd_defs:
  - Command constants LCD_FUNC_4BIT=8'h28, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - FSM state encoding.
- Sub-module lcd_nibble_writer:
  - Handshake: start / {rs, byte, single_nibble, long_wait} in, done pulse out.
  - Owns the E timing and post-byte wait counters.
  - The top FSM only sequences bytes.

Test Plan:
(Bench params: POWERUP_CYC=20, INIT_WAIT_CYC=10, E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8.)
- Release reset, no `cls` -> first E rise at cycle 21; init nibbles 3,3,3,2 with RS=0; then bytes 28,0C,06,01 as 8 nibbles; `busy` falls after the 01 wait; exactly 12 E pulses.
- After init, `strdata`="01234567 00 0123f01d01e01m01w01 ", 1-cycle `cls` ->
  - 68 E pulses; first byte 0x80 (RS=0).
  - Second byte '0' nibbles 3,0 (RS=1).
  - 18th byte 0xC0 (RS=0); 19th byte 'f' nibbles 6,6.
  - `busy` high for exactly 34*12=408 cycles.
- Change `strdata` to all 'A' one cycle after `cls` -> all 32 data bytes still match the original string (snapshot).
- Pulse `cls` 3 times during a refresh -> exactly one additional refresh follows with no idle gap; total 136 E pulses; `busy` stays continuously high.
- `cls` asserted during init -> refresh begins right after the 0x01 clear wait; `busy` never drops in between.
- Assert `rst`=0 while `lcd_e`=1 mid-refresh -> `lcd_e`, `lcd_d`, `lcd_rs` go 0 without waiting for a clock edge; `busy`=1; after release, full init replays from S_PWRUP with no pending refresh.
